// File: rtl/adc_lane_capture.sv
// rtl/adc_lane_capture.sv - triggered multi-lane ADC frame capture with serial lane readout
module adc_lane_capture #(
  parameter int LANES = 96,
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANES*WIDTH-1:0]   adc_data,
  input  logic                     adc_valid,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trig_mode,
  input  logic [WIDTH-1:0]         trig_thresh,
  input  logic [$clog2(DEPTH):0]   capture_len,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     done
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LNW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, READOUT} state_t;

  state_t state, state_nxt;

  logic                   cfg_mode;
  logic [WIDTH-1:0]       cfg_thresh;
  logic [LW-1:0]          cfg_len;
  logic [WIDTH-1:0]       prev_lane0;
  logic [LW-1:0]          wr_cnt;
  logic [AW-1:0]          rd_frame;
  logic [LNW-1:0]         rd_lane;
  logic [LANES*WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0]       lane0;
  logic [LW-1:0]          len_eff;
  logic [AW-1:0]          last_frame;
  logic [LANES*WIDTH-1:0] rd_word;
  logic [WIDTH-1:0]       rd_sample;
  logic                   trig_hit;
  logic                   cap_store;
  logic                   mem_we;
  logic [AW-1:0]          mem_wa;
  logic                   rd_load;
  logic                   rd_final_xfer;
  logic                   rd_at_end;

  assign lane0 = adc_data[WIDTH-1:0];

  always_comb begin
    len_eff = capture_len;
    if (capture_len == '0 || capture_len > LW'(DEPTH))
      len_eff = LW'(DEPTH);
  end

  // Rising crossing: current frame at/above threshold, previous valid frame below it.
  assign trig_hit  = adc_valid &&
                     (!cfg_mode || (lane0 >= cfg_thresh && prev_lane0 < cfg_thresh));
  assign cap_store = (state == CAPTURE) && adc_valid && (wr_cnt < cfg_len);
  assign mem_we    = !abort && (((state == WAIT_TRIG) && trig_hit) || cap_store);
  assign mem_wa    = (state == WAIT_TRIG) ? '0 : wr_cnt[AW-1:0];

  assign last_frame    = AW'(cfg_len - LW'(1));
  assign rd_word       = mem[rd_frame];
  assign rd_sample     = rd_word[rd_lane*WIDTH +: WIDTH];
  assign rd_at_end     = (rd_frame == last_frame) && (rd_lane == LNW'(LANES - 1));
  assign rd_load       = (state == READOUT) && (!rd_valid || (rd_ready && !rd_last));
  assign rd_final_xfer = (state == READOUT) && rd_valid && rd_ready && rd_last;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= adc_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (arm) state_nxt = WAIT_TRIG;
      WAIT_TRIG: if (trig_hit) state_nxt = CAPTURE;
      CAPTURE: begin
        if ((cap_store && (wr_cnt + LW'(1) == cfg_len)) || (wr_cnt >= cfg_len))
          state_nxt = READOUT;
      end
      READOUT:   if (rd_final_xfer) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (abort)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_mode   <= 1'b0;
      cfg_thresh <= '0;
      cfg_len    <= '0;
      prev_lane0 <= '0;
      wr_cnt     <= '0;
      rd_frame   <= '0;
      rd_lane    <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= rd_final_xfer && !abort;
      if (abort) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              cfg_mode   <= trig_mode;
              cfg_thresh <= trig_thresh;
              cfg_len    <= len_eff;
              prev_lane0 <= '0;
              wr_cnt     <= '0;
              rd_frame   <= '0;
              rd_lane    <= '0;
            end
          end
          WAIT_TRIG: begin
            if (adc_valid) begin
              prev_lane0 <= lane0;
              if (trig_hit)
                wr_cnt <= LW'(1);
            end
          end
          CAPTURE: begin
            if (cap_store)
              wr_cnt <= wr_cnt + LW'(1);
          end
          READOUT: begin
            if (rd_load) begin
              rd_data  <= rd_sample;
              rd_valid <= 1'b1;
              rd_last  <= rd_at_end;
              // Pointers park on the final sample instead of wrapping.
              if (!rd_at_end) begin
                if (rd_lane == LNW'(LANES - 1)) begin
                  rd_lane  <= '0;
                  rd_frame <= rd_frame + AW'(1);
                end else begin
                  rd_lane <= rd_lane + LNW'(1);
                end
              end
            end else if (rd_valid && rd_ready) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_lane_capture.sv
// tb/tb_adc_lane_capture.sv - scoreboard bench for adc_lane_capture
module tb_adc_lane_capture;

  localparam int LANES = 4;
  localparam int WIDTH = 9;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [LANES*WIDTH-1:0] adc_data;
  logic                   adc_valid;
  logic                   arm;
  logic                   abort;
  logic                   trig_mode;
  logic [WIDTH-1:0]       trig_thresh;
  logic [2:0]             capture_len;
  logic [WIDTH-1:0]       rd_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic                   rd_last;
  logic                   busy;
  logic                   done;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;
  int   cyc = 0;

  int               m_state = 0;
  logic             m_mode;
  logic [WIDTH-1:0] m_thr;
  logic [WIDTH-1:0] m_prev;
  int               m_len;
  int               m_cnt;

  always #5 clk = ~clk;

  adc_lane_capture #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_thresh(trig_thresh),
    .capture_len(capture_len), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = pat[cyc[1:0]];
        default: rd_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (done) done_cnt++;
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_sample", 32'(rd_data), 32'hFFFF_FFFF);
          end else begin
            check("rd_data", 32'(rd_data), 32'(exp_q[0].data));
            check("rd_last", 32'(rd_last), 32'(exp_q[0].last));
            if (rd_ready) begin
              void'(exp_q.pop_front());
              xfer_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic do_arm(input logic mode, input logic [WIDTH-1:0] thr, input logic [2:0] len);
    arm = 1'b1;
    trig_mode = mode;
    trig_thresh = thr;
    capture_len = len;
    if (m_state == 0 && !abort) begin
      m_state = 1;
      m_mode  = mode;
      m_thr   = thr;
      m_len   = (len == 0 || len > 3'(DEPTH)) ? DEPTH : int'(len);
      m_prev  = '0;
      m_cnt   = 0;
    end
    tick();
    arm = 1'b0;
  endtask

  task automatic send_frame(input logic v, input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1,
                            input logic [WIDTH-1:0] l2, input logic [WIDTH-1:0] l3, input logic a);
    logic [WIDTH-1:0] f[LANES];
    logic             hit;
    f[0] = l0; f[1] = l1; f[2] = l2; f[3] = l3;
    for (int i = 0; i < LANES; i++) adc_data[i*WIDTH +: WIDTH] = f[i];
    adc_valid = v;
    arm = a;
    if (v) begin
      if (m_state == 1) begin
        hit = !m_mode || (l0 >= m_thr && m_prev < m_thr);
        m_prev = l0;
        if (hit) begin
          m_state = 2;
          m_cnt = 0;
        end
      end
      if (m_state == 2 && m_cnt < m_len) begin
        m_cnt++;
        for (int i = 0; i < LANES; i++)
          exp_q.push_back(exp_t'{data: f[i], last: (m_cnt == m_len) && (i == LANES - 1)});
      end
    end
    tick();
    adc_valid = 1'b0;
    arm = 1'b0;
  endtask

  task automatic send_rand(input logic v);
    send_frame(v, 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom), 1'b0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_valid_at_done"}, 32'(rd_valid), 32'd0);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    m_state = 0;
    exp_q.delete();
  endtask

  task automatic expect_no_done(input string tag);
    int d0;
    d0 = done_cnt;
    repeat (6) tick();
    check(tag, 32'(done_cnt - d0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    adc_data = '0;
    adc_valid = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    trig_mode = 1'b0;
    trig_thresh = '0;
    capture_len = '0;
    repeat (3) tick();
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_last", 32'(rd_last), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    do_arm(1'b0, 9'h000, 3'd2);
    check("busy_after_arm", 32'(busy), 32'd1);
    send_frame(1'b1, 9'd1, 9'd2, 9'd3, 9'd4, 1'b0);
    send_frame(1'b1, 9'd5, 9'd6, 9'd7, 9'd8, 1'b0);
    wait_done("immediate", 100);

    do_arm(1'b1, 9'h100, 3'd2);
    send_frame(1'b1, 9'h0F0, 9'h011, 9'h012, 9'h013, 1'b0);
    send_frame(1'b1, 9'h120, 9'h021, 9'h022, 9'h023, 1'b0);
    send_frame(1'b1, 9'h080, 9'h031, 9'h032, 9'h033, 1'b0);
    send_frame(1'b1, 9'h150, 9'h041, 9'h042, 9'h043, 1'b0);
    wait_done("threshold", 100);

    ready_mode = 1;
    do_arm(1'b0, 9'h000, 3'd3);
    for (int k = 0; k < 3; k++) send_rand(1'b1);
    wait_done("backpressure", 200);
    ready_mode = 0;

    do_arm(1'b0, 9'h000, 3'd3);
    for (int k = 0; k < 6; k++) send_rand(k % 2 == 0);
    wait_done("gaps", 100);

    do_arm(1'b0, 9'h000, 3'd4);
    for (int k = 0; k < 4; k++) send_rand(1'b1);
    for (int i = 0; i < 100 && xfer_cnt < 3; i++) @(posedge clk);
    xfer_cnt = 0;
    ready_mode = 2;
    #1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rd_valid", 32'(rd_valid), 32'd0);
    check("abort_rd_last", 32'(rd_last), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    m_state = 0;
    ready_mode = 0;
    expect_no_done("abort_no_done");
    do_arm(1'b0, 9'h000, 3'd1);
    send_rand(1'b1);
    wait_done("rearm", 100);

    do_arm(1'b0, 9'h000, 3'd0);
    send_rand(1'b1);
    send_frame(1'b1, 9'h1AA, 9'h0BB, 9'h0CC, 9'h0DD, 1'b1);
    send_rand(1'b1);
    send_rand(1'b1);
    send_rand(1'b1);
    wait_done("len_zero", 100);

    ready_mode = 2;
    do_arm(1'b0, 9'h000, 3'd2);
    send_rand(1'b1);
    send_rand(1'b1);
    begin
      logic seen_v;
      seen_v = 1'b0;
      for (int i = 0; i < 20 && !seen_v; i++) begin
        @(negedge clk);
        seen_v = rd_valid;
      end
      check("readout_started", 32'(seen_v), 32'd1);
    end
    reset = 1'b1;
    #2;
    check("midreset_rd_valid", 32'(rd_valid), 32'd0);
    check("midreset_rd_last", 32'(rd_last), 32'd0);
    check("midreset_rd_data", 32'(rd_data), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    exp_q.delete();
    m_state = 0;
    ready_mode = 0;
    tick();
    reset = 1'b0;
    expect_no_done("midreset_no_done");
    check("midreset_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_lane_capture.md
ADC_LANE_CAPTURE -- requirements
Module: adc_lane_capture

Interface
REQ-001 The block SHALL have parameter LANES, default 96, meaning number of parallel ADC lanes per frame.
REQ-002 The block SHALL have parameter WIDTH, default 9, meaning bits per ADC sample (offset-binary, MSB=1 means positive).
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning capture buffer depth in frames (power of 2).
REQ-004 The block SHALL have port clk, input, 1, capture clock (ADC frame clock domain).
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port adc_data, input, LANES*WIDTH, one frame: lane i at bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port adc_valid, input, 1, adc_data holds a valid frame this cycle.
REQ-008 The block SHALL have port arm, input, 1, single-cycle pulse that starts a capture.
REQ-009 The block SHALL have port abort, input, 1, forces return to IDLE.
REQ-010 The block SHALL have port trig_mode, input, 1, 0 = immediate, 1 = threshold on lane 0.
REQ-011 The block SHALL have port trig_thresh, input, WIDTH, unsigned threshold for lane 0.
REQ-012 The block SHALL have port capture_len, input, $clog2(DEPTH)+1, frames to capture; 0 or >DEPTH is treated as DEPTH.
REQ-013 The block SHALL have port rd_data, output, WIDTH, readout sample.
REQ-014 The block SHALL have port rd_valid, output, 1, rd_data valid.
REQ-015 The block SHALL have port rd_ready, input, 1, downstream accepts rd_data.
REQ-016 The block SHALL have port rd_last, output, 1, final sample of the capture; qualified by rd_valid.
REQ-017 The block SHALL have port busy, output, 1, state is not IDLE.
REQ-018 The block SHALL have port done, output, 1, one-cycle pulse when readout completes.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT_TRIG, CAPTURE, READOUT.
REQ-020 In IDLE, arm SHALL latch trig_mode, trig_thresh and the effective capture_len, then go to WAIT_TRIG; arm in any other state SHALL be ignored.
REQ-021 In WAIT_TRIG with trig_mode=0, the first cycle with adc_valid=1 SHALL be the trigger frame.
REQ-022 In WAIT_TRIG with trig_mode=1, the trigger frame SHALL be the first valid frame where lane0 >= thresh and the previous valid frame's lane0 < thresh.
REQ-023 The previous-lane0 register SHALL be reset to 0 on arm, so a first frame at or above thresh triggers.
REQ-024 The trigger frame SHALL be stored as buffer frame 0, and the FSM SHALL enter CAPTURE in the same transition.
REQ-025 In CAPTURE, each adc_valid=1 frame SHALL be stored at the next frame index; adc_valid=0 cycles SHALL store nothing.
REQ-026 When the stored-frame count reaches the latched length, the FSM SHALL enter READOUT on the next cycle.
REQ-027 Readout order SHALL be frame 0 lane 0, frame 0 lane 1, ..., frame 0 lane LANES-1, frame 1 lane 0, and so on.
REQ-028 rd_valid SHALL rise no later than 2 cycles after READOUT entry.
REQ-029 A sample SHALL transfer on a cycle with rd_valid && rd_ready.
REQ-030 While rd_valid && !rd_ready, rd_data and rd_last SHALL be held stable.
REQ-031 rd_valid SHALL deassert only after the last sample transfers.
REQ-032 rd_last SHALL be 1 only on sample (len*LANES - 1).
REQ-033 On the cycle after the last transfer, done SHALL pulse for 1 cycle, the FSM SHALL enter IDLE, and rd_valid SHALL be 0.
REQ-034 abort SHALL have priority over all events and return the FSM to IDLE on the next cycle with rd_valid=0, rd_last=0, and no done pulse.
REQ-035 arm and abort asserted in the same IDLE cycle SHALL leave the FSM in IDLE.
REQ-036 Frame and lane index counters SHALL saturate at their terminal value and never wrap.
REQ-037 Buffer contents SHALL be undefined outside the captured range and SHALL never be emitted.

Reset
REQ-038 Reset SHALL force state IDLE, rd_valid=0, rd_last=0, rd_data=0, busy=0, done=0, all counters=0 and latched config=0.
REQ-039 Reset asserted mid-capture or mid-readout SHALL discard the capture, and no done pulse SHALL follow.
REQ-040 Buffer RAM contents SHALL NOT require reset.

Verification
REQ-041 Immediate mode (LANES=4, DEPTH=4, len=2): arm, then frames lanes {1,2,3,4} and {5,6,7,8} with valid=1 -> 8 samples 1..8 are read, rd_last on 8, then done pulse.
REQ-042 Threshold mode (thresh=0x100): lane0 sequence 0x0F0, 0x120, 0x080, 0x150 -> frame 0 is the 0x120 frame, not the 0x150 frame.
REQ-043 Backpressure: rd_ready toggles 1,0,0,1,... -> no sample lost or duplicated, and rd_data is stable during stalls.
REQ-044 Gaps: adc_valid=0 on alternate CAPTURE cycles -> only valid frames are stored, in order.
REQ-045 abort in READOUT after 3 transfers -> IDLE next cycle, rd_valid=0, done=0; a new arm then captures normally.
REQ-046 len=0 -> DEPTH frames captured; arm pulsed during CAPTURE is ignored; reset during READOUT -> all outputs return to reset values.
